// File: rtl/ram_arbiter.sv
// Shared RAM port arbiter for the dual-core system: data before instruction,
// round-robin between CPUs within a class, and a starvation guard for fetches.
//
// state | meaning
// IDLE  | no RAM enable driven; pick a winner from live requests, latch it
// XFER  | drive latched access to RAM until ACCESS (complete) or request drop (abort)
//
// ramstate encoding: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
module ram_arbiter #(
    parameter int CPUS         = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int WORD_W       = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [1:0]          iREN,
    input  logic [2*WORD_W-1:0] iaddr,
    input  logic [1:0]          dREN,
    input  logic [1:0]          dWEN,
    input  logic [2*WORD_W-1:0] daddr,
    input  logic [2*WORD_W-1:0] dstore,
    output logic [1:0]          iwait,
    output logic [1:0]          dwait,
    output logic [2*WORD_W-1:0] iload,
    output logic [2*WORD_W-1:0] dload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [WORD_W-1:0]   ramaddr,
    output logic [WORD_W-1:0]   ramstore,
    input  logic [WORD_W-1:0]   ramload,
    input  logic [1:0]          ramstate
);

    localparam int              ID_W       = $clog2(CPUS);
    localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STARVE_LIMIT);
    localparam logic [1:0]      RAM_ACCESS = 2'd2;

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state, state_nx;
    logic [ID_W-1:0]   own_id;
    logic              own_dat;
    logic              own_wr;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] store_q;
    logic [ID_W-1:0]   d_rr, i_rr;
    logic [CNT_W-1:0]  starve_cnt;

    logic [1:0]        d_req;
    logic              any_i, starve_hit, pick_d, pick_i;
    logic [ID_W-1:0]   d_win, i_win;
    logic              owner_live, done;

    assign iload = {2{ramload}};
    assign dload = {2{ramload}};

    assign d_req      = dREN | dWEN;
    assign any_i      = |iREN;
    assign starve_hit = (starve_cnt == LIMIT);
    assign pick_d     = (|d_req) && !(starve_hit && any_i);
    assign pick_i     = !pick_d && any_i;
    assign d_win      = d_req[d_rr] ? d_rr : ~d_rr;
    assign i_win      = iREN[i_rr]  ? i_rr : ~i_rr;

    // The owner must keep asserting the request for the op it was granted.
    assign owner_live = own_dat ? (own_wr ? dWEN[own_id] : dREN[own_id]) : iREN[own_id];
    assign done       = (state == XFER) && owner_live && (ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 2'b11;
        dwait    = 2'b11;
        case (state)
            IDLE: begin
                if (pick_d || pick_i) state_nx = XFER;
            end
            XFER: begin
                ramaddr  = addr_q;
                ramstore = store_q;
                ramREN   = !own_wr;
                ramWEN   = own_wr;
                if (!owner_live) begin
                    state_nx = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    state_nx = IDLE;
                    if (own_dat) dwait[own_id] = 1'b0;
                    else         iwait[own_id] = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            own_id     <= '0;
            own_dat    <= 1'b0;
            own_wr     <= 1'b0;
            addr_q     <= '0;
            store_q    <= '0;
            d_rr       <= '0;
            i_rr       <= '0;
            starve_cnt <= '0;
        end else begin
            if (state == IDLE && (pick_d || pick_i)) begin
                own_dat <= pick_d;
                own_id  <= pick_d ? d_win : i_win;
                own_wr  <= pick_d && dWEN[d_win];
                if (pick_d) begin
                    addr_q  <= d_win[0] ? daddr[2*WORD_W-1:WORD_W]  : daddr[WORD_W-1:0];
                    store_q <= d_win[0] ? dstore[2*WORD_W-1:WORD_W] : dstore[WORD_W-1:0];
                end else begin
                    addr_q  <= i_win[0] ? iaddr[2*WORD_W-1:WORD_W]  : iaddr[WORD_W-1:0];
                    store_q <= '0;
                end
            end
            // Pointers move past the serviced CPU only on real completion.
            if (done) begin
                if (own_dat) begin
                    d_rr <= ~own_id;
                    if (!any_i)          starve_cnt <= '0;
                    else if (!starve_hit) starve_cnt <= starve_cnt + CNT_W'(1);
                end else begin
                    i_rr       <= ~own_id;
                    starve_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a transaction-level model predicts each
// grant; a monitor pops and compares whenever a wait bit goes low.
module tb_ram_arbiter;

    localparam int W = 32;
    localparam int LIMIT = 4;
    localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

    logic          CLK, nRST;
    logic [1:0]    iREN, dREN, dWEN;
    logic [2*W-1:0] iaddr, daddr, dstore;
    logic [1:0]    iwait, dwait;
    logic [2*W-1:0] iload, dload;
    logic          ramREN, ramWEN;
    logic [W-1:0]  ramaddr, ramstore, ramload;
    logic [1:0]    ramstate;

    ram_arbiter #(.CPUS(2), .STARVE_LIMIT(LIMIT), .WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic         dat;
        logic         cpu;
        logic         wr;
        logic [W-1:0] addr;
        logic [W-1:0] store;
    } exp_t;

    exp_t exq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // requester intent and reference-model arbitration state
    logic [1:0]   p_iren, p_dren, p_dwen;
    logic [W-1:0] p_iaddr[2], p_daddr[2], p_dstore[2];
    logic         m_d_rr, m_i_rr;
    int           m_starve;
    int           ram_mode;  // 0 random latency, 1 hold BUSY, 2 hold ERROR
    int           lat;

    task automatic check(string name, logic [2*W-1:0] act, logic [2*W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic finish_bench();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic drive();
        iREN   = p_iren;
        dREN   = p_dren;
        dWEN   = p_dwen;
        iaddr  = {p_iaddr[1], p_iaddr[0]};
        daddr  = {p_daddr[1], p_daddr[0]};
        dstore = {p_dstore[1], p_dstore[0]};
    endtask

    function automatic exp_t predict();
        exp_t e;
        logic [1:0] dq;
        dq = p_dren | p_dwen;
        e  = '0;
        if (dq != 0 && !(m_starve == LIMIT && p_iren != 0)) begin
            e.dat   = 1'b1;
            e.cpu   = dq[m_d_rr] ? m_d_rr : !m_d_rr;
            e.wr    = p_dwen[e.cpu];
            e.addr  = p_daddr[e.cpu];
            e.store = p_dstore[e.cpu];
        end else begin
            e.dat  = 1'b0;
            e.cpu  = p_iren[m_i_rr] ? m_i_rr : !m_i_rr;
            e.addr = p_iaddr[e.cpu];
        end
        return e;
    endfunction

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (iwait != 2'b11 || dwait != 2'b11) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One granted transaction: predict, wait for completion, retire in the model.
    task automatic step_txn();
        exp_t e;
        bit   ok;
        e = predict();
        exq.push_back(e);
        drive();
        wait_pulse(ok);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL completion_timeout: no wait pulse within 200 cycles, expected cpu %0d dat %0d", e.cpu, e.dat);
            finish_bench();
        end
        if (e.dat) begin
            m_d_rr   = !e.cpu;
            m_starve = (p_iren != 0) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            p_dren[e.cpu] = 1'b0;
            p_dwen[e.cpu] = 1'b0;
        end else begin
            m_i_rr   = !e.cpu;
            m_starve = 0;
            p_iren[e.cpu] = 1'b0;
        end
        @(posedge CLK);
        #1;
        drive();
    endtask

    task automatic refill();
        for (int c = 0; c < 2; c++) begin
            if (!p_iren[c] && $urandom_range(0, 2) == 0) begin
                p_iren[c]  = 1'b1;
                p_iaddr[c] = $urandom;
            end
            if (!p_dren[c] && !p_dwen[c] && $urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 2))
                    0:       p_dren[c] = 1'b1;
                    1:       p_dwen[c] = 1'b1;
                    default: begin p_dren[c] = 1'b1; p_dwen[c] = 1'b1; end
                endcase
                p_daddr[c]  = $urandom;
                p_dstore[c] = $urandom;
            end
        end
        if ((p_iren | p_dren | p_dwen) == 2'b00) begin
            p_iren[0]  = 1'b1;
            p_iaddr[0] = $urandom;
        end
    endtask

    task automatic clear_reqs();
        p_iren = '0; p_dren = '0; p_dwen = '0;
        drive();
    endtask

    // RAM model: random wait states before ACCESS unless a mode pins the state.
    initial begin
        ramstate = S_FREE;
        ramload  = '0;
        lat      = 0;
        forever begin
            @(posedge CLK);
            #1;
            ramload = $urandom;
            if (ram_mode == 1)      ramstate = S_BUSY;
            else if (ram_mode == 2) ramstate = S_ERROR;
            else if (ramREN || ramWEN) begin
                if (lat == 0) begin
                    ramstate = S_ACCESS;
                    lat      = $urandom_range(0, 3);
                end else begin
                    lat--;
                    case ($urandom_range(0, 2))
                        0:       ramstate = S_FREE;
                        1:       ramstate = S_BUSY;
                        default: ramstate = S_ERROR;
                    endcase
                end
            end else begin
                ramstate = 2'($urandom_range(0, 3));
            end
        end
    end

    // Monitor: every wait pulse must match the oldest predicted grant.
    exp_t       mon_e;
    logic [3:0] mon_low;
    always @(negedge CLK) begin
        if (nRST === 1'b1 && {iwait, dwait} != 4'hF) begin
            if (exq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: iwait=%b dwait=%b with no grant expected", iwait, dwait);
            end else begin
                mon_e   = exq.pop_front();
                mon_low = 4'hF;
                mon_low[mon_e.dat ? int'(mon_e.cpu) : 2 + int'(mon_e.cpu)] = 1'b0;
                check("wait_bits", 64'({iwait, dwait}), 64'(mon_low));
                check("ramaddr", 64'(ramaddr), 64'(mon_e.addr));
                check("ramWEN", 64'(ramWEN), 64'(mon_e.wr));
                check("ramREN", 64'(ramREN), 64'(!mon_e.wr));
                if (mon_e.wr) check("ramstore", 64'(ramstore), 64'(mon_e.store));
                check("iload", iload, {2{ramload}});
                check("dload", dload, {2{ramload}});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        ram_mode = 0;
        m_d_rr = 1'b0; m_i_rr = 1'b0; m_starve = 0;
        for (int c = 0; c < 2; c++) begin
            p_iaddr[c] = '0; p_daddr[c] = '0; p_dstore[c] = '0;
        end
        clear_reqs();
        repeat (3) @(negedge CLK);
        check("rst_ramREN", 64'(ramREN), 64'd0);
        check("rst_ramWEN", 64'(ramWEN), 64'd0);
        check("rst_ramaddr", 64'(ramaddr), 64'd0);
        check("rst_ramstore", 64'(ramstore), 64'd0);
        check("rst_iwait", 64'(iwait), 64'd3);
        check("rst_dwait", 64'(dwait), 64'd3);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // both CPUs reading data continuously: grants alternate
        p_daddr[0] = 32'h100; p_daddr[1] = 32'h200;
        for (int k = 0; k < 3; k++) begin
            p_dren = 2'b11;
            step_txn();
        end
        clear_reqs();

        // data write competes with a fetch: write first, then the fetch
        p_dwen[0] = 1'b1; p_daddr[0] = 32'h40; p_dstore[0] = 32'hDEADBEEF;
        p_iren[1] = 1'b1; p_iaddr[1] = 32'h80;
        step_txn();
        step_txn();

        // ERROR stretches a read; the wait bit stays high until ACCESS
        ram_mode = 2;
        p_dren = 2'b01; p_daddr[0] = 32'h500;
        fork
            step_txn();
            begin
                @(negedge CLK);
                for (int k = 0; k < 10; k++) begin
                    @(negedge CLK);
                    check("err_ramREN", 64'(ramREN), 64'd1);
                    check("err_dwait", 64'(dwait), 64'd3);
                end
                ram_mode = 0;
            end
        join

        // starvation guard: fetch wins after LIMIT data grants
        p_iren = 2'b01; p_iaddr[0] = 32'h700;
        p_daddr[0] = 32'h600; p_daddr[1] = 32'h680;
        for (int k = 0; k <= LIMIT; k++) begin
            p_dren = 2'b11;
            step_txn();
        end
        clear_reqs();

        // abort: dropping the request ends XFER without pulse or pointer move
        ram_mode = 1;
        p_dren = 2'b10; p_daddr[1] = 32'h300;
        drive();
        @(negedge CLK);
        @(negedge CLK);
        check("abort_ramREN_on", 64'(ramREN), 64'd1);
        check("abort_ramaddr", 64'(ramaddr), 64'h300);
        p_dren = 2'b00;
        drive();
        @(negedge CLK);
        check("abort_ramREN_off", 64'(ramREN), 64'd0);
        check("abort_dwait", 64'(dwait), 64'd3);
        p_dren = 2'b11; p_daddr[0] = 32'h310; p_daddr[1] = 32'h320;
        drive();
        @(negedge CLK);
        check("abort_rr_kept", 64'(ramaddr), m_d_rr ? 64'h320 : 64'h310);
        clear_reqs();
        repeat (2) @(negedge CLK);
        ram_mode = 0;
        @(posedge CLK);
        #1;

        // give d_rr a non-reset value, then reset in the middle of a write
        p_dren = 2'b01; p_daddr[0] = 32'h900;
        step_txn();
        ram_mode = 1;
        p_dwen = 2'b01; p_daddr[0] = 32'h40; p_dstore[0] = 32'hDEADBEEF;
        drive();
        @(negedge CLK);
        @(negedge CLK);
        check("rstx_ramWEN_on", 64'(ramWEN), 64'd1);
        nRST = 1'b0;
        #1;
        check("rstx_ramWEN", 64'(ramWEN), 64'd0);
        check("rstx_ramaddr", 64'(ramaddr), 64'd0);
        check("rstx_ramstore", 64'(ramstore), 64'd0);
        check("rstx_dwait", 64'(dwait), 64'd3);
        m_d_rr = 1'b0; m_i_rr = 1'b0; m_starve = 0;
        clear_reqs();
        @(negedge CLK);
        nRST = 1'b1;
        p_dren = 2'b11; p_daddr[0] = 32'h910; p_daddr[1] = 32'h920;
        drive();
        @(negedge CLK);
        @(negedge CLK);
        check("rstx_rr_restart", 64'(ramaddr), 64'h910);
        clear_reqs();
        repeat (2) @(negedge CLK);
        ram_mode = 0;
        @(posedge CLK);
        #1;

        // randomized traffic against the model
        for (int k = 0; k < 150; k++) begin
            refill();
            step_txn();
        end
        clear_reqs();
        repeat (3) @(negedge CLK);
        check("queue_drained", 64'(exq.size()), 64'd0);
        finish_bench();
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequences the single shared RAM port among four requesters: icache0, icache1, dcache0 and dcache1 of the dual-core system.
- Data requests have priority over instruction requests. Round-robin fairness applies between the two CPUs within each class.
- A starvation guard lets a pending instruction fetch win after a bounded run of data grants.
- Sits between the cache/coherence side and the RAM model. It owns ramREN, ramWEN, ramaddr and ramstore.

Parameters:
- CPUS, 2, number of cores; fixed at 2 in this revision.
- STARVE_LIMIT, 4, consecutive data grants allowed while any iREN is pending before instruction class is forced.
- WORD_W, 32, data/address width (word_t).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- iREN  input  [1:0]  instruction read request per CPU.
- iaddr  input  2x WORD_W  instruction address per CPU.
- dREN  input  [1:0]  data read request per CPU.
- dWEN  input  [1:0]  data write request per CPU.
- daddr  input  2x WORD_W  data address per CPU.
- dstore  input  2x WORD_W  write data per CPU.
- iwait  output  [1:0]  low for exactly the completing cycle of that CPU's fetch.
- dwait  output  [1:0]  low for exactly the completing cycle of that CPU's data access.
- iload  output  2x WORD_W  ramload broadcast to both CPUs.
- dload  output  2x WORD_W  ramload broadcast to both CPUs.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  WORD_W  RAM address.
- ramstore  output  WORD_W  RAM write data.
- ramload  input  WORD_W  RAM read data.
- ramstate  input  ramstate_t  FREE, BUSY, ACCESS or ERROR.

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE; all RAM enables and data are 0: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=2'b11, dwait=2'b11.
  - Both round-robin pointers (d_rr, i_rr) = 0; starve_cnt=0.
  - Reset mid-transfer abandons the access with no wait pulse.
- States: IDLE, XFER.
- IDLE arbitration and grant:
  - Requests are sampled combinationally.
  - Class pick: data class if any dREN|dWEN is set and not (starve_cnt==STARVE_LIMIT with any iREN set). Otherwise instruction class if any iREN is set.
  - Within a class, the CPU equal to the class rr pointer wins if it is requesting; otherwise the other CPU wins.
  - The winner's id, class, op (write if dWEN, else read; dWEN beats dREN on the same CPU), addr and store data are registered. Next state is XFER.
  - There is exactly one cycle of arbitration latency. The RAM sees no enable in IDLE.
- XFER:
  - ramaddr and ramstore are driven from the latched values.
  - ramREN=1 for reads; ramWEN=1 for writes; never both.
  - BUSY or ERROR: hold; all waits stay high.
  - ACCESS: drive the owner's wait bit low this cycle; all other wait bits stay high. Next state is IDLE.
  - On that ACCESS cycle, the rr pointer of the serviced class toggles to the other CPU.
  - starve_cnt update on ACCESS:
    - Data grant with an iREN pending: increment, saturating at STARVE_LIMIT.
    - Instruction grant: clear to 0.
    - Data grant with no iREN pending: clear to 0.
  - FREE while in XFER is treated as BUSY.
- Abort: if the owner's request bit for the latched op drops during XFER, deassert ram enables next cycle and return to IDLE. No wait pulse, no pointer or counter update.
- Back-to-back: a requester holding its request after completion is re-arbitrated in the following IDLE cycle. Minimum issue rate is one access per 2 + RAM-latency cycles.
- iload and dload equal ramload continuously; consumers qualify them with their wait bit.

Test Plan:
- dREN=2'b11 held, daddr0=0x100, daddr1=0x200, ramstate ACCESS after 2 cycles -> grants alternate CPU0, CPU1, CPU0. ramaddr sequence is 0x100, 0x200, 0x100. dwait pulses low one cycle per grant.
- dWEN[0]=1 with dstore0=0xDEADBEEF, addr 0x40, plus iREN[1]=1 simultaneously -> data is served first: ramWEN=1, ramaddr=0x40, ramstore=0xDEADBEEF, dwait[0] low. The next grant is the fetch: ramREN=1, iwait[1] low.
- dREN=2'b11 and iREN[0] held continuously, STARVE_LIMIT=4 -> after 4 data completions, the 5th grant is the instruction fetch to iaddr0 and starve_cnt returns to 0.
- Granted read with ramstate=ERROR for 10 cycles, then ACCESS -> ramREN stays 1 and the wait bit stays high for all 10 cycles. The wait bit is low only on the ACCESS cycle.
- During XFER of a dREN[1] read, dREN[1] is dropped -> ramREN=0 next cycle, state returns to IDLE, dwait stays 2'b11, and d_rr is unchanged.
- nRST asserted mid-XFER write -> immediately ramWEN=0, ramaddr=0, dwait=2'b11. After release, arbitration restarts with d_rr=0.
